// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush scheduler with divider sequencing and wrong-path fetch discard
module pipe_ctrl #(
    parameter int PC_W    = 32,
    parameter int MAX_OUT = 2
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic            id_valid,
    input  logic            id_load_use,
    input  logic            ex_valid,
    input  logic            ex_is_div,
    input  logic            div_done,
    input  logic            ex_br_taken,
    input  logic [PC_W-1:0] ex_br_target,
    input  logic            wb_valid,
    input  logic            wb_exc,
    input  logic            wb_ertn,
    input  logic [PC_W-1:0] exc_entry,
    input  logic [PC_W-1:0] era,
    input  logic            if_req_fire,
    input  logic            if_resp_fire,
    output logic            rg_if,
    output logic            rg_id,
    output logic            rg_ex,
    output logic            flush_if,
    output logic            flush_id,
    output logic            flush_ex,
    output logic            flush_mem,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            div_start,
    output logic            div_cancel,
    output logic            if_resp_discard,
    output logic            if_req_block,
    output logic [31:0]     stall_cycles
);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);
    typedef enum logic {RUN, DIV_WAIT} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] out_q, out_d, disc_q, disc_d;
    logic [31:0] stall_q, stall_d;
    logic e, b, div_hold;
    always_comb begin
        e               = ~areset & wb_valid & (wb_exc | wb_ertn);
        div_hold        = ~areset & (state_q == RUN) & ex_valid & ex_is_div & ~e;
        rg_if           = areset | (disc_q == '0);
        rg_id           = areset | ~(id_valid & id_load_use);
        rg_ex           = areset | ((state_q == DIV_WAIT) ? div_done : ~div_hold);
        b               = ~areset & ex_valid & ex_br_taken & rg_ex & ~e;
        flush_if        = areset | e | b;
        flush_id        = areset | e | b;
        flush_ex        = areset | e;
        flush_mem       = areset | e;
        redirect_valid  = e | b;
        redirect_pc     = e ? (wb_exc ? exc_entry : era) : ex_br_target;
        div_start       = div_hold;
        div_cancel      = ~areset & (state_q == DIV_WAIT) & e;
        if_resp_discard = ~areset & (disc_q != '0);
        if_req_block    = ~areset & (out_q == MAX_C);
        stall_cycles    = areset ? '0 : stall_q;
        out_d           = out_q + CW'(if_req_fire) - CW'(if_resp_fire);
        // everything still in flight after a redirect belongs to the old path
        disc_d          = (e | b) ? out_d : (if_resp_fire && disc_q != '0) ? disc_q - 1'b1 : disc_q;
        stall_d         = (~(rg_if & rg_id & rg_ex) && stall_q != '1) ? stall_q + 32'd1 : stall_q;
        state_d         = (state_q == DIV_WAIT) ? ((e | div_done) ? RUN : DIV_WAIT)
                                                : (div_hold ? DIV_WAIT : RUN);
    end
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= RUN;
            out_q   <= '0;
            disc_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
            stall_q <= stall_d;
        end
    end
    always_ff @(posedge aclk) begin
        if (!areset) begin
            assert (!(if_req_fire && !if_resp_fire && out_q == MAX_C));
            assert (!(if_resp_fire && !if_req_fire && out_q == '0));
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: randomized and directed checks of pipe_ctrl against a queue-based model
module tb_pipe_ctrl;
    localparam int PC_W = 32;
    localparam int MAX_OUT = 3;
    logic aclk = 1'b0;
    logic areset, id_valid, id_load_use, ex_valid, ex_is_div, div_done, ex_br_taken;
    logic wb_valid, wb_exc, wb_ertn, if_req_fire, if_resp_fire;
    logic [PC_W-1:0] ex_br_target, exc_entry, era, redirect_pc;
    logic rg_if, rg_id, rg_ex, flush_if, flush_id, flush_ex, flush_mem, redirect_valid;
    logic div_start, div_cancel, if_resp_discard, if_req_block;
    logic [31:0] stall_cycles;

    always #5 aclk = ~aclk;

    pipe_ctrl #(.PC_W(PC_W), .MAX_OUT(MAX_OUT)) dut (
        .aclk(aclk), .areset(areset), .id_valid(id_valid), .id_load_use(id_load_use),
        .ex_valid(ex_valid), .ex_is_div(ex_is_div), .div_done(div_done),
        .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target), .wb_valid(wb_valid),
        .wb_exc(wb_exc), .wb_ertn(wb_ertn), .exc_entry(exc_entry), .era(era),
        .if_req_fire(if_req_fire), .if_resp_fire(if_resp_fire), .rg_if(rg_if), .rg_id(rg_id),
        .rg_ex(rg_ex), .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex),
        .flush_mem(flush_mem), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .div_start(div_start), .div_cancel(div_cancel), .if_resp_discard(if_resp_discard),
        .if_req_block(if_req_block), .stall_cycles(stall_cycles)
    );

    int checks = 0;
    int failures = 0;
    bit in_div;
    bit wq[$];
    longint unsigned stall;
    bit m_e, m_b, m_start, m_rgif, m_rgid, m_rgex;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic predict();
        int wrong = 0;
        foreach (wq[i]) wrong += int'(wq[i]);
        m_e     = wb_valid & (wb_exc | wb_ertn);
        m_start = !in_div && ex_valid && ex_is_div && !m_e;
        m_rgex  = in_div ? div_done : !(ex_valid && ex_is_div && !m_e);
        m_b     = ex_valid && ex_br_taken && m_rgex && !m_e;
        m_rgid  = !(id_valid && id_load_use);
        m_rgif  = (wrong == 0);
    endtask

    task automatic model_check();
        if (areset) begin
            chk("rst_flush", {flush_if, flush_id, flush_ex, flush_mem}, 4'hF);
            chk("rst_rg", {rg_if, rg_id, rg_ex}, 3'h7);
            chk("rst_ctl", {redirect_valid, div_start, div_cancel, if_req_block, if_resp_discard}, 5'h0);
            chk("rst_stall", stall_cycles, 32'h0);
        end else begin
            chk("rg", {rg_if, rg_id, rg_ex}, {m_rgif, m_rgid, m_rgex});
            chk("flush", {flush_if, flush_id, flush_ex, flush_mem}, {m_e | m_b, m_e | m_b, m_e, m_e});
            chk("redirect_valid", redirect_valid, m_e | m_b);
            if (m_e | m_b)
                chk("redirect_pc", redirect_pc, m_e ? (wb_exc ? exc_entry : era) : ex_br_target);
            chk("div_start", div_start, m_start);
            chk("div_cancel", div_cancel, in_div && m_e);
            chk("discard", if_resp_discard, !m_rgif);
            chk("req_block", if_req_block, wq.size() == MAX_OUT);
            chk("stall_cycles", stall_cycles, stall[31:0]);
        end
    endtask

    task automatic model_update();
        if (areset) begin
            in_div = 0;
            wq.delete();
            stall = 0;
        end else begin
            if (!(m_rgif && m_rgid && m_rgex) && stall < 64'hFFFF_FFFF) stall++;
            in_div = in_div ? !(m_e || div_done) : m_start;
            if (if_resp_fire) void'(wq.pop_front());
            if (if_req_fire) wq.push_back(1'b0);
            if (m_e || m_b) foreach (wq[i]) wq[i] = 1'b1;
        end
    endtask

    task automatic settle();
        #1;
        predict();
        model_check();
    endtask

    task automatic tick();
        @(posedge aclk);
        model_update();
        @(negedge aclk);
    endtask

    task automatic idle();
        areset = 0; id_valid = 0; id_load_use = 0; ex_valid = 0; ex_is_div = 0; div_done = 0;
        ex_br_taken = 0; ex_br_target = '0; wb_valid = 0; wb_exc = 0; wb_ertn = 0;
        exc_entry = '0; era = '0; if_req_fire = 0; if_resp_fire = 0;
    endtask

    initial begin
        idle();
        areset = 1;
        @(negedge aclk);
        settle(); tick();
        settle(); tick();
        idle();
        settle();
        chk("post_rst_rg", {rg_if, rg_id, rg_ex}, 3'h7);
        chk("post_rst_stall", stall_cycles, 32'h0);
        tick();

        id_valid = 1; id_load_use = 1;
        settle();
        chk("lu_rg_id", rg_id, 1'b0);
        chk("lu_stall0", stall_cycles, 32'd0);
        tick();
        idle();
        settle();
        chk("lu_rg_id_after", rg_id, 1'b1);
        chk("lu_stall1", stall_cycles, 32'd1);
        tick();

        ex_valid = 1; ex_is_div = 1;
        for (int c = 0; c <= 6; c++) begin
            div_done = (c == 5);
            settle();
            chk("div_start_seq", div_start, (c == 0) || (c == 6));
            chk("div_rg_ex_seq", rg_ex, c == 5);
            tick();
        end
        div_done = 0; wb_valid = 1; wb_exc = 1; exc_entry = 32'h1C00_8000;
        settle();
        chk("exc_flush", {flush_if, flush_id, flush_ex, flush_mem}, 4'hF);
        chk("exc_cancel", div_cancel, 1'b1);
        chk("exc_no_start", div_start, 1'b0);
        chk("exc_pc", redirect_pc, 32'h1C00_8000);
        tick();
        idle(); ex_valid = 1; ex_is_div = 1;
        settle();
        chk("exc_back_run", div_start, 1'b1);
        tick();
        div_done = 1;
        settle(); tick();
        idle();

        if_req_fire = 1;
        settle(); tick();
        settle(); tick();
        ex_valid = 1; ex_br_taken = 1; ex_br_target = 32'h1C00_0100;
        settle();
        chk("br_flush", {flush_if, flush_id, flush_ex, flush_mem}, 4'hC);
        chk("br_pc", redirect_pc, 32'h1C00_0100);
        tick();
        idle();
        settle();
        chk("br_block", if_req_block, 1'b1);
        if_resp_fire = 1;
        for (int r = 0; r < 3; r++) begin
            settle();
            chk("br_discard", if_resp_discard, 1'b1);
            tick();
        end
        idle(); if_req_fire = 1;
        settle(); tick();
        idle(); if_resp_fire = 1;
        settle();
        chk("br_4th_kept", if_resp_discard, 1'b0);
        tick();
        idle();

        wb_valid = 1; wb_ertn = 1; era = 32'h1C00_0040;
        ex_valid = 1; ex_br_taken = 1; ex_br_target = 32'h1C00_0200;
        settle();
        chk("eb_pc", redirect_pc, 32'h1C00_0040);
        chk("eb_flush_ex", flush_ex, 1'b1);
        tick();
        idle();

        if_req_fire = 1;
        settle(); tick();
        settle(); tick();
        idle(); ex_valid = 1; ex_br_taken = 1; ex_br_target = 32'h1C00_0300;
        settle(); tick();
        idle();
        settle();
        chk("drain_discard", if_resp_discard, 1'b1);
        tick();
        areset = 1;
        settle();
        chk("drain_rst_flush", {flush_if, flush_id, flush_ex, flush_mem}, 4'hF);
        tick();
        idle();
        settle();
        chk("drain_rg_if", rg_if, 1'b1);
        chk("drain_stall", stall_cycles, 32'h0);
        tick();

        for (int n = 0; n < 3000; n++) begin
            areset       = ($urandom_range(0, 199) == 0);
            id_valid     = 1'($urandom_range(0, 1));
            id_load_use  = ($urandom_range(0, 3) == 0);
            ex_valid     = 1'($urandom_range(0, 1));
            ex_is_div    = ($urandom_range(0, 7) == 0);
            ex_br_taken  = ($urandom_range(0, 5) == 0);
            ex_br_target = $urandom;
            div_done     = ($urandom_range(0, 4) == 0);
            wb_valid     = 1'($urandom_range(0, 1));
            wb_exc       = ($urandom_range(0, 15) == 0);
            wb_ertn      = ($urandom_range(0, 15) == 0);
            exc_entry    = $urandom;
            era          = $urandom;
            if_req_fire  = (wq.size() < MAX_OUT) && ($urandom_range(0, 1) == 1);
            if_resp_fire = (wq.size() > 0) && ($urandom_range(0, 1) == 1);
            settle();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush scheduler for the five-stage in-order core. Each cycle it drives `ready_go` for IF, ID and EX, drives `flush` for IF, ID, EX and MEM, and redirects fetch on a taken branch or an exception/ertn commit. It also sequences the multi-cycle divider. It tracks outstanding instruction-fetch bus requests so that wrong-path responses are discarded after a redirect. It sits beside the stage registers and feeds their `ready_go`/`flush` pins directly.

## Interface
Parameters:
- `PC_W`, 32, PC/target width.
- `MAX_OUT`, 2, maximum outstanding fetch requests; the counter width is clog2(MAX_OUT+1).

Ports:
- `aclk` in 1: clock.
- `areset` in 1: reset, synchronous, active-high.
- `id_valid`, `id_load_use` in 1: ID holds a valid instruction that consumes the load currently in EX.
- `ex_valid`, `ex_is_div` in 1: EX holds a valid divide.
- `div_done` in 1: divider result valid (one-cycle pulse).
- `ex_br_taken` in 1; `ex_br_target` in PC_W: EX branch resolved taken.
- `wb_valid`, `wb_exc`, `wb_ertn` in 1: WB commits an exception or ertn.
- `exc_entry`, `era` in PC_W: exception entry PC and return PC.
- `if_req_fire`, `if_resp_fire` in 1: fetch request accepted; fetch response accepted (in order).
- `rg_if`, `rg_id`, `rg_ex` out 1: ready_go per stage.
- `flush_if`, `flush_id`, `flush_ex`, `flush_mem` out 1: active-high stage flush.
- `redirect_valid` out 1; `redirect_pc` out PC_W.
- `div_start`, `div_cancel` out 1: divider control pulses.
- `if_resp_discard` out 1: the current fetch response is wrong-path.
- `if_req_block` out 1: the outstanding limit has been reached.
- `stall_cycles` out 32: saturating perf counter.

## Operation
- State: FSM {RUN, DIV_WAIT}; `out_cnt`; `discard_cnt`; `stall_cycles`. All are cleared by `areset`; the FSM resets to RUN.
- Exception event E = wb_valid & (wb_exc | wb_ertn).
  - Asserts `flush_if`, `flush_id`, `flush_ex`, `flush_mem` and `redirect_valid`.
  - `redirect_pc` = wb_exc ? exc_entry : era (wb_exc wins if both are set).
- Branch event B = ex_valid & ex_br_taken & rg_ex & ~E.
  - Asserts `flush_if`, `flush_id` and `redirect_valid`; `redirect_pc` = ex_br_target.
- Load-use stall: `rg_id` = ~(id_valid & id_load_use).
- Divide sequencing:
  - In RUN, ex_valid & ex_is_div & ~E asserts `div_start` for one cycle, drives `rg_ex`=0 and moves the FSM to DIV_WAIT.
  - In DIV_WAIT, `rg_ex` = div_done; on div_done the FSM returns to RUN.
  - E in DIV_WAIT asserts `div_cancel` and returns the FSM to RUN; `div_start` is never asserted in a cycle with E.
- Outstanding fetch counter:
  - out_nxt = out_cnt + if_req_fire − if_resp_fire; simultaneous fire leaves it unchanged.
  - `if_req_block` = (out_cnt == MAX_OUT).
- Discard counter:
  - On E or B: discard_cnt ← out_nxt. Requests issued in the redirect cycle are wrong-path. A response in the redirect cycle is already flushed via `flush_if`.
  - Otherwise, if_resp_fire & discard_cnt≠0 decrements it.
  - A redirect during drain overwrites the count (re-arm).
- `if_resp_discard` = (discard_cnt ≠ 0); `rg_if` = ~if_resp_discard.
- `stall_cycles` increments when any of rg_if/rg_id/rg_ex is 0; it saturates at 0xFFFF_FFFF.

## Timing
- All outputs are combinational from the current inputs and registered state, with zero-cycle latency. Stage registers sample `flush`/`ready_go` at the next aclk edge.
- During `areset`:
  - All four flushes are forced to 1.
  - redirect_valid, div_start, div_cancel, if_req_block and if_resp_discard are forced to 0.
  - rg_* are forced to 1 and stall_cycles reads 0.
- First cycle after reset: state RUN, counters 0.
- `div_start` is exactly one cycle per divide, aligned with EX entry. The divide result is consumed on the div_done cycle, and EX advances that same edge.
- Divide back-to-back: the second div_start comes in the cycle after div_done (RUN re-entry).
- Reset asserted mid-divide or mid-drain clears everything. The divider is not pulsed with cancel; it is reset by the same `areset`.
- Overflow/underflow of out_cnt is an illegal input (upstream honours `if_req_block`); it is flagged by an assertion, not handled.

## Test plan
- Load-use: id_valid=1, id_load_use=1 for 1 cycle -> rg_id=0 that cycle only; stall_cycles 0→1.
- Divide: ex_valid=ex_is_div=1, div_done at cycle +5 -> div_start at cycle 0 only; rg_ex=0 for cycles 0–4 and 1 at cycle 5; FSM back in RUN at cycle 6.
- Branch with 2 outstanding fetches plus one request firing in the same cycle, target 0x1C000100 -> flush_if/id=1, flush_ex/mem=0, redirect_pc=0x1C000100, discard_cnt=3; the next 3 responses have if_resp_discard=1 and the 4th has 0.
- Exception during DIV_WAIT, wb_exc=1, exc_entry=0x1C008000 -> all four flushes, div_cancel=1, div_start=0, redirect_pc=0x1C008000, next state RUN.
- E and B in the same cycle with ertn, era=0x1C000040 -> redirect_pc=0x1C000040 and flush_ex=1; the branch is ignored.
- Reset asserted mid-drain (discard_cnt=2) -> flushes=1 during reset; afterwards discard_cnt=0, rg_if=1, stall_cycles=0.
